// File: rtl/press_code_decoder.sv
// rtl/press_code_decoder.sv - debounced button press decoder into short/long code words
// Optional abort-on-very-long-press feature enabled by defining PRESS_ABORT_EN.
module press_code_decoder #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 6000000,
  parameter int GAP_CYCLES      = 24000000,
  parameter int MAX_SYMBOLS     = 8
`ifdef PRESS_ABORT_EN
  , parameter int ABORT_CYCLES  = 36000000
`endif
) (
  input  logic                   hwclk,
  input  logic                   rst,
  input  logic                   btn_in,
  output logic                   sym_valid,
  output logic                   sym_long,
  output logic [MAX_SYMBOLS-1:0] code,
  output logic [3:0]             code_len,
  output logic                   code_valid,
  input  logic                   code_ack,
  output logic                   overflow
`ifdef PRESS_ABORT_EN
  , output logic                 abort
`endif
);

`ifdef PRESS_ABORT_EN
  localparam int SAT_CYCLES = ABORT_CYCLES;
`else
  localparam int SAT_CYCLES = LONG_CYCLES;
`endif
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PCW = $clog2(SAT_CYCLES + 1);
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, PRESSED, RELEASED, HOLD} state_t;

  logic [1:0]     sync_q;
  logic [DBW-1:0] db_cnt_q;
  logic           btn_db_q, btn_db_prev_q;
  logic           btn_s, db_rise, db_fall;

  assign btn_s   = sync_q[1];
  assign db_rise = btn_db_q & ~btn_db_prev_q;
  assign db_fall = ~btn_db_q & btn_db_prev_q;

  always_ff @(posedge hwclk) begin
    if (rst) begin
      sync_q        <= '0;
      db_cnt_q      <= '0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], btn_in};
      btn_db_prev_q <= btn_db_q;
      if (btn_s == btn_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
        btn_db_q <= ~btn_db_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  state_t                 state_q, state_d;
  logic [PCW-1:0]         press_q, press_d;
  logic [GCW-1:0]         gap_q, gap_d;
  logic [MAX_SYMBOLS-1:0] code_q, code_d;
  logic [3:0]             len_q, len_d;
  logic                   cv_q, cv_d, ovf_q, ovf_d;
  logic                   sv_q, sv_d, sl_q, sl_d, abort_q, abort_d;
  logic                   sym, abort_hit;

`ifdef PRESS_ABORT_EN
  assign abort_hit = (press_q >= PCW'(ABORT_CYCLES));
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    press_d = press_q;
    gap_d   = gap_q;
    code_d  = code_q;
    len_d   = len_q;
    cv_d    = cv_q;
    ovf_d   = ovf_q;
    sv_d    = 1'b0;
    sl_d    = 1'b0;
    abort_d = 1'b0;
    sym     = (press_q >= PCW'(LONG_CYCLES));
    case (state_q)
      IDLE: begin
        if (db_rise) begin
          state_d = PRESSED;
          press_d = '0;
        end
      end
      PRESSED: begin
        if (db_fall) begin
          if (abort_hit) begin
            code_d  = '0;
            len_d   = '0;
            ovf_d   = 1'b0;
            abort_d = 1'b1;
            state_d = IDLE;
          end else begin
            sv_d = 1'b1;
            sl_d = sym;
            if (len_q < 4'(MAX_SYMBOLS)) begin
              for (int i = 0; i < MAX_SYMBOLS; i++) begin
                if (len_q == 4'(i)) code_d[i] = sym;
              end
              len_d = len_q + 4'd1;
            end else begin
              ovf_d = 1'b1;
            end
            state_d = RELEASED;
            gap_d   = '0;
          end
        end else if (press_q < PCW'(SAT_CYCLES)) begin
          press_d = press_q + 1'b1;
        end
      end
      RELEASED: begin
        // A new press wins over a timeout landing in the same cycle.
        if (db_rise) begin
          state_d = PRESSED;
          press_d = '0;
        end else if (gap_q == GCW'(GAP_CYCLES - 1)) begin
          state_d = HOLD;
          cv_d    = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      HOLD: begin
        if (code_ack) begin
          state_d = IDLE;
          cv_d    = 1'b0;
          code_d  = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q <= IDLE;
      press_q <= '0;
      gap_q   <= '0;
      code_q  <= '0;
      len_q   <= '0;
      cv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      sv_q    <= 1'b0;
      sl_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      gap_q   <= gap_d;
      code_q  <= code_d;
      len_q   <= len_d;
      cv_q    <= cv_d;
      ovf_q   <= ovf_d;
      sv_q    <= sv_d;
      sl_q    <= sl_d;
      abort_q <= abort_d;
    end
  end

  assign sym_valid  = sv_q;
  assign sym_long   = sl_q;
  assign code       = code_q;
  assign code_len   = len_q;
  assign code_valid = cv_q;
  assign overflow   = ovf_q;
`ifdef PRESS_ABORT_EN
  assign abort      = abort_q;
`endif

endmodule

// File: tb/tb_press_code_decoder.sv
// tb/tb_press_code_decoder.sv - randomized bench for press_code_decoder against a word-level model
module tb_press_code_decoder;
  localparam int D = 4, L = 20, G = 50, M = 4, A = 60;

  logic         hwclk = 1'b0, rst = 1'b1, btn_in = 1'b0, code_ack = 1'b0;
  logic         sym_valid, sym_long, code_valid, overflow;
  logic [M-1:0] code;
  logic [3:0]   code_len;
  int           checks = 0, errors = 0, abort_seen = 0;
  bit           obs[$];

`ifdef PRESS_ABORT_EN
  logic abort;
  press_code_decoder #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .GAP_CYCLES(G),
                       .MAX_SYMBOLS(M), .ABORT_CYCLES(A)) dut (
    .hwclk(hwclk), .rst(rst), .btn_in(btn_in), .sym_valid(sym_valid), .sym_long(sym_long),
    .code(code), .code_len(code_len), .code_valid(code_valid), .code_ack(code_ack),
    .overflow(overflow), .abort(abort));
  always @(negedge hwclk) if (abort) abort_seen++;
`else
  press_code_decoder #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .GAP_CYCLES(G),
                       .MAX_SYMBOLS(M)) dut (
    .hwclk(hwclk), .rst(rst), .btn_in(btn_in), .sym_valid(sym_valid), .sym_long(sym_long),
    .code(code), .code_len(code_len), .code_valid(code_valid), .code_ack(code_ack),
    .overflow(overflow));
`endif

  always #5 hwclk = ~hwclk;
  always @(negedge hwclk) if (sym_valid) obs.push_back(sym_long);

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge hwclk);
    #1;
  endtask

  task automatic press(int h, int l);
    btn_in = 1'b1;
    cyc(h);
    btn_in = 1'b0;
    cyc(l);
  endtask

  task automatic wait_cv(string tag, int budget);
    int t = 0;
    while (!code_valid && t < budget) begin
      @(negedge hwclk);
      t++;
    end
    check({tag, "_cv"}, code_valid, 1);
  endtask

  task automatic do_ack(string tag);
    code_ack = 1'b1;
    cyc(1);
    code_ack = 1'b0;
    check({tag, "_ack_cv"}, code_valid, 0);
    check({tag, "_ack_len"}, code_len, 0);
    check({tag, "_ack_code"}, code, 0);
    check({tag, "_ack_ovf"}, overflow, 0);
  endtask

  // Word-level model: symbols in order, first M kept, the rest only set overflow.
  task automatic check_word(string tag, bit syms[$]);
    int          n = syms.size();
    int          exp_len = (n < M) ? n : M;
    logic [31:0] exp_code = 0, exp_obs = 0, got_obs = 0;
    for (int i = 0; i < exp_len; i++) exp_code[i] = syms[i];
    for (int i = 0; i < n; i++) exp_obs[i] = syms[i];
    for (int i = 0; i < obs.size() && i < 32; i++) got_obs[i] = obs[i];
    check({tag, "_nsym"}, obs.size(), n);
    check({tag, "_symcls"}, got_obs, exp_obs);
    check({tag, "_len"}, code_len, exp_len);
    check({tag, "_code"}, code, exp_code);
    check({tag, "_ovf"}, overflow, (n > M) ? 1 : 0);
    obs.delete();
  endtask

  task automatic run_word(string tag, int highs[$], int gap);
    bit syms[$];
    foreach (highs[i]) begin
      syms.push_back(highs[i] >= L);
      press(highs[i], gap);
    end
    wait_cv(tag, 200);
    check_word(tag, syms);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  t, n;
    int  hs[$];
    bit  syms[$];

    cyc(3);
    check("rst_sv", sym_valid, 0);
    check("rst_cv", code_valid, 0);
    check("rst_len", code_len, 0);
    check("rst_code", code, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    cyc(2);

    // Single short press; code_valid follows the symbol pulse after GAP cycles.
    btn_in = 1'b1;
    cyc(10);
    btn_in = 1'b0;
    t = 0;
    while (!sym_valid && t < 40) begin
      @(negedge hwclk);
      t++;
    end
    check("s1_symseen", sym_valid, 1);
    check("s1_cv_with_sym", code_valid, 0);
    t = 0;
    while (!code_valid && t < 100) begin
      @(negedge hwclk);
      t++;
    end
    check("s1_gap_latency", t, G);
    cyc(1);
    syms = {1'b0};
    check_word("s1", syms);
    do_ack("s1");

    hs = {8, 30, 8};
    run_word("s2", hs, 15);
    do_ack("s2");

    for (int i = 0; i < 40; i++) begin
      btn_in = 1'b1;
      cyc($urandom_range(1, 3));
      btn_in = 1'b0;
      cyc($urandom_range(2, 6));
    end
    cyc(80);
    check("s3_nsym", obs.size(), 0);
    check("s3_cv", code_valid, 0);

    hs = {8, 8, 8, 8, 8};
    run_word("s4", hs, 12);
    do_ack("s4");

    hs = {10};
    run_word("s5a", hs, 10);
    btn_in = 1'b1;
    cyc(30);
    code_ack = 1'b1;
    cyc(1);
    code_ack = 1'b0;
    check("s5_cv_drop", code_valid, 0);
    cyc(30);
    btn_in = 1'b0;
    cyc(80);
    check("s5_held_nsym", obs.size(), 0);
    check("s5_held_cv", code_valid, 0);
    hs = {30};
    run_word("s5b", hs, 10);
    do_ack("s5b");

    press(8, 15);
    press(8, 15);
    btn_in = 1'b1;
    cyc(15);
    check("s6_pre_len", code_len, 2);
    rst = 1'b1;
    cyc(1);
    check("s6_rst_len", code_len, 0);
    check("s6_rst_code", code, 0);
    check("s6_rst_sv", sym_valid, 0);
    check("s6_rst_cv", code_valid, 0);
    check("s6_rst_ovf", overflow, 0);
    rst = 1'b0;
    obs.delete();
    cyc(12);
    btn_in = 1'b0;
    wait_cv("s6b", 200);
    syms = {1'b0};
    check_word("s6b", syms);
    do_ack("s6b");

`ifdef PRESS_ABORT_EN
    press(8, 15);
    press(8, 15);
    press(70, 20);
    check("ab_pulses", abort_seen, 1);
    check("ab_len", code_len, 0);
    check("ab_nsym", obs.size(), 2);
    cyc(80);
    check("ab_cv", code_valid, 0);
    obs.delete();
`endif

    for (int w = 0; w < 15; w++) begin
      hs.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        hs.push_back(($urandom_range(0, 1) == 1) ? $urandom_range(25, 40) : $urandom_range(5, 15));
      run_word($sformatf("rnd%0d", w), hs, $urandom_range(8, 30));
      do_ack($sformatf("rnd%0d", w));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/press_code_decoder.md
Name: press_code_decoder

Overview:
- Receive-side counterpart to the LED blink generator. It decodes timed presses on the keypad button into short and long symbols.
- Accumulates symbols into a code word. An inter-symbol silence timeout ends the word.
- Presents the finished word to the lock controller with a valid/ack handshake.
- Sits between the raw button pin and the lock controller FSM.

Parameters:
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles before the debounced level changes (10 ms @ 12 MHz).
- LONG_CYCLES, 6000000, a press of this many debounced-high cycles or more is a long symbol (0.5 s).
- GAP_CYCLES, 24000000, debounced-low cycles after the last symbol that end the word (2 s).
- MAX_SYMBOLS, 8, code buffer depth in symbols (1..15).

Ports:
- hwclk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- btn_in  input  1  raw asynchronous button, active-high.
- sym_valid  output  1  one-cycle pulse when a symbol is decoded.
- sym_long  output  1  class of the current symbol (1 = long); valid while sym_valid is high.
- code  output  MAX_SYMBOLS  symbol buffer; bit i = i-th symbol, 1 = long.
- code_len  output  4  number of stored symbols.
- code_valid  output  1  word complete; held until acked.
- code_ack  input  1  controller accepts the word.
- overflow  output  1  sticky; a symbol was dropped because the buffer was full.

Behaviour:
- Synchronous reset, active-high, single clock domain.
- Input path:
  - btn_in passes through a 2-flop synchronizer, giving btn_s.
  - Debounce counter resets whenever btn_s equals btn_db, otherwise increments.
  - When the count reaches DEBOUNCE_CYCLES-1, btn_db toggles.
  - btn_db lags a clean edge by DEBOUNCE_CYCLES+2 cycles.
- Reset values: all outputs 0, btn_db=0, all counters 0, state IDLE.
- FSM states: IDLE, PRESSED, RELEASED, HOLD.
  - IDLE: on btn_db rise → PRESSED and press_cnt=0. No timeout in IDLE.
  - PRESSED: press_cnt increments, saturating at LONG_CYCLES. On btn_db fall:
    - symbol = (press_cnt >= LONG_CYCLES).
    - If code_len < MAX_SYMBOLS: code[code_len] <= symbol, code_len++.
    - Otherwise: overflow <= 1 and the symbol is discarded.
    - sym_valid pulses with sym_long = symbol in both cases.
    - Go to RELEASED with gap_cnt=0.
  - RELEASED: gap_cnt increments.
    - On btn_db rise → PRESSED.
    - When gap_cnt reaches GAP_CYCLES-1 → HOLD and code_valid <= 1.
    - A rise in the same cycle as the timeout takes priority: go to PRESSED.
  - HOLD: code, code_len and overflow are frozen and button activity is ignored. On code_ack:
    - Next cycle: code_valid=0, code=0, code_len=0, overflow=0, state IDLE.
    - A press still held at ack is not decoded. IDLE requires a fresh btn_db rise.
- code_ack outside HOLD is ignored.
- sym_valid is never high in the same cycle as code_valid's rising edge.
- Reset mid-press or mid-word: everything is cleared. A button still held after reset is decoded as a new press once debounced (btn_db rises from its reset value 0).
- Counters are wide enough for their parameter (clog2) and never wrap. press_cnt saturates.

Optional Feature:
- Macro: PRESS_ABORT_EN.
- When defined:
  - Parameter ABORT_CYCLES (default 36000000, 3 s) and output port abort (1 bit) are added.
  - A press lasting at least ABORT_CYCLES aborts the word on release: no symbol is stored, no sym_valid.
  - code, code_len and overflow are cleared, abort pulses for one cycle, and the FSM returns to IDLE.
  - press_cnt saturates at ABORT_CYCLES.
- When undefined: no abort port exists and any press of LONG_CYCLES or more is a long symbol.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, GAP_CYCLES=50, MAX_SYMBOLS=4.
1. Single clean 10-cycle press, then idle → one sym_valid with sym_long=0. 50 cycles after the debounced fall: code_valid=1, code_len=1, code=4'b0000.
2. Presses of 8, 30 and 8 cycles, each separated by 15-cycle gaps → three sym_valid pulses with sym_long 0,1,0; then code=4'b0010, code_len=3.
3. btn_in glitches of 1–3 cycles over a long low period → btn_db never rises, no sym_valid, no code_valid.
4. Five short presses → code_len=4, code=0, overflow=1 after the 5th. Asserting code_ack clears code_valid, code_len and overflow on the next cycle.
5. Press during HOLD, then code_ack while the button is still held → no symbol decoded. code_valid drops after ack. A subsequent release followed by a new press decodes normally.
6. rst asserted during a 15-cycle press with code_len=2 → next cycle all outputs are 0. With PRESS_ABORT_EN and ABORT_CYCLES=60, a 70-cycle press yields an abort pulse and code_len=0.
